// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator controller.
// Holds the car state enum and the floor/count widths and limits.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN,
        HALT
    } elev_state_t;

    localparam int FLOOR_W = 2;
    localparam int CNT_W   = 4;

    localparam logic [FLOOR_W-1:0] MAX_FLOOR = 2'd3;
    localparam logic [CNT_W-1:0]   CNT_MAX   = 4'd15;

endpackage

// File: rtl/elevator_if.sv
// Request/position bundle between the floor-request logic and the car.
// master: drives stop/in, sees floor/changes_count. slave: the controller.
interface elevator_if;
    import elevator_pkg::*;

    logic               stop;
    logic [FLOOR_W-1:0] in;
    logic [FLOOR_W-1:0] floor;
    logic [CNT_W-1:0]   changes_count;

    modport master (
        output stop,
        output in,
        input  floor,
        input  changes_count
    );

    modport slave (
        input  stop,
        input  in,
        output floor,
        output changes_count
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses, holds at all-ones.
// Ports: clk, rst_n (async active-low clear), inc, count.
module sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/elevator.sv
// Single-car, four-floor elevator controller with emergency hold.
// Ports: clk, rst (async active-low), bus (stop, in, floor, changes_count).
module elevator
    import elevator_pkg::*;
#(
    parameter int MOVE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    elevator_if.slave  bus
);

    localparam logic [3:0] LAST = 4'(MOVE_CYCLES - 1);

    elev_state_t        state_q, state_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic [3:0]         timer_q, timer_d;
    logic [3:0]         eff;
    logic               go_up, go_dn;
    logic               step;

    assign go_up = !bus.stop && (bus.in > floor_q);
    assign go_dn = !bus.stop && (bus.in < floor_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            floor_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        timer_d = timer_q;
        eff     = '0;
        step    = 1'b0;
        unique case (1'b1)
            bus.stop: begin
                state_d = HALT;
                timer_d = '0;
            end
            go_up: begin
                state_d = UP;
                // Travel time only carries over while still heading up.
                eff = (state_q == UP) ? timer_q : '0;
                if (eff == LAST) begin
                    timer_d = '0;
                    if (floor_q != MAX_FLOOR) begin
                        floor_d = floor_q + 1'b1;
                        step    = 1'b1;
                    end
                end else begin
                    timer_d = eff + 1'b1;
                end
            end
            go_dn: begin
                state_d = DOWN;
                eff = (state_q == DOWN) ? timer_q : '0;
                if (eff == LAST) begin
                    timer_d = '0;
                    if (floor_q != '0) begin
                        floor_d = floor_q - 1'b1;
                        step    = 1'b1;
                    end
                end else begin
                    timer_d = eff + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (step),
        .count (bus.changes_count)
    );

    assign bus.floor = floor_q;

endmodule

// File: tb/tb_elevator.sv
// Directed self-checking bench for elevator.
// Runs one car with MOVE_CYCLES=1 and one with MOVE_CYCLES=3.
module tb_elevator;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    elevator_if a_if ();
    elevator_if b_if ();

    elevator #(.MOVE_CYCLES(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    elevator #(.MOVE_CYCLES(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst       = 1'b0;
        a_if.stop = 1'b0;
        a_if.in   = 2'd0;
        b_if.stop = 1'b0;
        b_if.in   = 2'd0;

        #12;
        check("rst_floor_a", int'(a_if.floor), 0);
        check("rst_cnt_a", int'(a_if.changes_count), 0);
        check("rst_floor_b", int'(b_if.floor), 0);
        rst = 1'b1;

        // climb 0 -> 3, one floor per edge
        a_if.in = 2'd3;
        tick();
        check("up_1", int'(a_if.floor), 1);
        tick();
        check("up_2", int'(a_if.floor), 2);
        tick();
        check("up_3", int'(a_if.floor), 3);
        tick();
        check("up_hold", int'(a_if.floor), 3);
        check("up_cnt", int'(a_if.changes_count), 3);

        // retarget mid-travel
        a_if.in = 2'd1;
        tick();
        check("rt_2", int'(a_if.floor), 2);
        tick();
        check("rt_1", int'(a_if.floor), 1);
        a_if.in = 2'd2;
        tick();
        check("rt_back", int'(a_if.floor), 2);
        check("rt_cnt", int'(a_if.changes_count), 6);

        // emergency hold
        a_if.in   = 2'd0;
        a_if.stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stop_floor", int'(a_if.floor), 2);
            check("stop_cnt", int'(a_if.changes_count), 6);
        end
        a_if.stop = 1'b0;
        tick();
        check("resume_floor", int'(a_if.floor), 1);
        check("resume_cnt", int'(a_if.changes_count), 7);

        // saturation while toggling between 0 and 1
        for (int i = 0; i < 20; i++) begin
            a_if.in = (i % 2 == 0) ? 2'd0 : 2'd1;
            tick();
            check("sat_floor", int'(a_if.floor), (i % 2 == 0) ? 0 : 1);
            check("sat_cnt", int'(a_if.changes_count),
                  (8 + i > 15) ? 15 : 8 + i);
        end

        // asynchronous reset mid-travel
        a_if.in = 2'd3;
        tick();
        check("pre_rst_floor", int'(a_if.floor), 2);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_floor", int'(a_if.floor), 0);
        check("async_rst_cnt", int'(a_if.changes_count), 0);
        a_if.in = 2'd0;
        tick();
        rst = 1'b1;

        // MOVE_CYCLES=3: three edges per floor
        b_if.in = 2'd2;
        tick();
        tick();
        check("m3_e2", int'(b_if.floor), 0);
        tick();
        check("m3_e3", int'(b_if.floor), 1);
        tick();
        tick();
        check("m3_e5", int'(b_if.floor), 1);
        tick();
        check("m3_e6", int'(b_if.floor), 2);
        check("m3_cnt", int'(b_if.changes_count), 2);

        // stop pulse discards partial travel
        b_if.in = 2'd0;
        tick();
        tick();
        b_if.stop = 1'b1;
        tick();
        check("m3_stop", int'(b_if.floor), 2);
        b_if.stop = 1'b0;
        tick();
        tick();
        check("m3_restart2", int'(b_if.floor), 2);
        tick();
        check("m3_restart3", int'(b_if.floor), 1);
        check("m3_cnt2", int'(b_if.changes_count), 3);

        // direction reversal discards partial travel
        tick();
        tick();
        b_if.in = 2'd3;
        tick();
        check("rev_e1", int'(b_if.floor), 1);
        tick();
        check("rev_e2", int'(b_if.floor), 1);
        tick();
        check("rev_e3", int'(b_if.floor), 2);
        check("rev_cnt", int'(b_if.changes_count), 4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
